mips32: RTL and testbench

MIPS32 -- requirements
Module: mips32

---
 rtl/mips32.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mips32.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32.sv
// mips32: five-stage in-order pipeline (IF/ID/EX/MEM/WB) with word-indexed
// instruction and data memories, operand forwarding, load-use interlock,
// branch resolution in EX with a two-instruction squash, and HLT.

module mips32_regfile (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] Reg [0:31];

  // Write port; no reset so preloaded contents survive
  always_ff @(posedge clk) begin
    if (we_i) Reg[waddr_i] <= wdata_i;
  end

  // Read ports; a write in the same cycle is passed through so ID sees the new value
  always_comb begin
    rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : Reg[raddr1_i];
    rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : Reg[raddr2_i];
  end
endmodule

module mips32 (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);
  typedef enum logic [5:0] {
    OP_ADD   = 6'b000000, OP_SUB   = 6'b000001, OP_AND  = 6'b000010,
    OP_OR    = 6'b000011, OP_SLT   = 6'b000100, OP_MUL  = 6'b000101,
    OP_LW    = 6'b001000, OP_SW    = 6'b001001, OP_ADDI = 6'b001010,
    OP_SUBI  = 6'b001011, OP_SLTI  = 6'b001100, OP_BNEQZ = 6'b001101,
    OP_BEQZ  = 6'b001110, OP_J     = 6'b010000, OP_HLT  = 6'b111111
  } opcode_e;

  logic [31:0] Mem_C [0:1023];
  logic [31:0] Mem_D [0:1023];

  // IF/ID
  logic [31:0] PC, IF_ID_IR, IF_ID_NPC;
  logic        IF_ID_valid;
  // ID/EX
  logic [31:0] ID_EX_IR, ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_Imm;
  logic        ID_EX_valid, ID_EX_wr;
  logic [4:0]  ID_EX_dst;
  // EX/MEM
  logic [5:0]  EX_MEM_op;
  logic [31:0] EX_MEM_AluOut, EX_MEM_B;
  logic        EX_MEM_Cond, EX_MEM_valid, EX_MEM_wr;
  logic [4:0]  EX_MEM_dst;
  // MEM/WB
  logic [5:0]  MEM_WB_op;
  logic [31:0] MEM_WB_AluOut, MEM_WB_LMD;
  logic        MEM_WB_valid, MEM_WB_wr;
  logic [4:0]  MEM_WB_dst;

  logic [5:0]  id_op, ex_op;
  logic [4:0]  id_rs, id_rt, id_rd, id_dst, ex_rs, ex_rt;
  logic [31:0] id_imm, id_a, id_b;
  logic        id_use_rs, id_use_rt, id_wr;
  logic        taken, stall, hlt_seen, rf_we;
  logic [31:0] wb_data, ex_alu;
  logic        ex_cond;
  logic [1:0]  ctrl1, ctrl2;
  logic [31:0] mux_EX_out1, mux_EX_out2;

  // ID decode: field split, sign extension, source usage and destination
  always_comb begin
    id_op     = IF_ID_IR[31:26];
    id_rs     = IF_ID_IR[25:21];
    id_rt     = IF_ID_IR[20:16];
    id_rd     = IF_ID_IR[15:11];
    id_imm    = {{16{IF_ID_IR[15]}}, IF_ID_IR[15:0]};
    id_use_rs = 1'b0;
    id_use_rt = 1'b0;
    id_wr     = 1'b0;
    id_dst    = id_rd;
    case (id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        id_use_rs = 1'b1; id_use_rt = 1'b1; id_wr = 1'b1; id_dst = id_rd;
      end
      OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: begin
        id_use_rs = 1'b1; id_wr = 1'b1; id_dst = id_rt;
      end
      OP_SW: begin
        id_use_rs = 1'b1; id_use_rt = 1'b1;
      end
      OP_BEQZ, OP_BNEQZ: id_use_rs = 1'b1;
      default: ;
    endcase
  end

  mips32_regfile R1 (
    .clk      (clk),
    .we_i     (rf_we),
    .waddr_i  (MEM_WB_dst),
    .wdata_i  (wb_data),
    .raddr1_i (id_rs),
    .raddr2_i (id_rt),
    .rdata1_o (id_a),
    .rdata2_o (id_b)
  );

  // Hazard detection: taken branch, pending HLT, load-use interlock, WB result
  always_comb begin
    ex_op    = ID_EX_IR[31:26];
    ex_rs    = ID_EX_IR[25:21];
    ex_rt    = ID_EX_IR[20:16];
    taken    = EX_MEM_valid & EX_MEM_Cond;
    hlt_seen = (IF_ID_valid  & (id_op     == OP_HLT)) |
               (ID_EX_valid  & (ex_op     == OP_HLT)) |
               (EX_MEM_valid & (EX_MEM_op == OP_HLT)) |
               (MEM_WB_valid & (MEM_WB_op == OP_HLT));
    stall    = IF_ID_valid & ID_EX_valid & (ex_op == OP_LW) &
               ((id_use_rs & (id_rs == ex_rt)) | (id_use_rt & (id_rt == ex_rt)));
    wb_data  = (MEM_WB_op == OP_LW) ? MEM_WB_LMD : MEM_WB_AluOut;
    rf_we    = MEM_WB_valid & MEM_WB_wr & ~halted;
  end

  // Forwarding select; the EX/MEM match is tested last so the youngest writer wins
  always_comb begin
    ctrl1 = 2'd0;
    ctrl2 = 2'd0;
    if (MEM_WB_valid && MEM_WB_wr && (MEM_WB_dst == ex_rs)) ctrl1 = 2'd2;
    if (EX_MEM_valid && EX_MEM_wr && (EX_MEM_dst == ex_rs)) ctrl1 = 2'd1;
    if (MEM_WB_valid && MEM_WB_wr && (MEM_WB_dst == ex_rt)) ctrl2 = 2'd2;
    if (EX_MEM_valid && EX_MEM_wr && (EX_MEM_dst == ex_rt)) ctrl2 = 2'd1;
    case (ctrl1)
      2'd1:    mux_EX_out1 = EX_MEM_AluOut;
      2'd2:    mux_EX_out1 = wb_data;
      default: mux_EX_out1 = ID_EX_A;
    endcase
    case (ctrl2)
      2'd1:    mux_EX_out2 = EX_MEM_AluOut;
      2'd2:    mux_EX_out2 = wb_data;
      default: mux_EX_out2 = ID_EX_B;
    endcase
  end

  // EX: ALU result, effective address or branch/jump target, and branch condition
  always_comb begin
    ex_alu  = '0;
    ex_cond = 1'b0;
    case (ex_op)
      OP_ADD:  ex_alu = mux_EX_out1 + mux_EX_out2;
      OP_SUB:  ex_alu = mux_EX_out1 - mux_EX_out2;
      OP_AND:  ex_alu = mux_EX_out1 & mux_EX_out2;
      OP_OR:   ex_alu = mux_EX_out1 | mux_EX_out2;
      OP_SLT:  ex_alu = {31'b0, $signed(mux_EX_out1) < $signed(mux_EX_out2)};
      OP_MUL:  ex_alu = mux_EX_out1 * mux_EX_out2;
      OP_ADDI, OP_LW, OP_SW: ex_alu = mux_EX_out1 + ID_EX_Imm;
      OP_SUBI: ex_alu = mux_EX_out1 - ID_EX_Imm;
      OP_SLTI: ex_alu = {31'b0, $signed(mux_EX_out1) < $signed(ID_EX_Imm)};
      OP_BEQZ: begin
        ex_alu  = ID_EX_NPC + ID_EX_Imm;
        ex_cond = (mux_EX_out1 == '0);
      end
      OP_BNEQZ: begin
        ex_alu  = ID_EX_NPC + ID_EX_Imm;
        ex_cond = (mux_EX_out1 != '0);
      end
      OP_J: begin
        ex_alu  = {6'b0, ID_EX_IR[25:0]};
        ex_cond = 1'b1;
      end
      default: ;
    endcase
  end

  // IF: redirect on a taken branch, stop fetching behind HLT, hold on load-use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC          <= '0;
      IF_ID_IR    <= '0;
      IF_ID_NPC   <= '0;
      IF_ID_valid <= 1'b0;
    end else if (!halted) begin
      if (taken) begin
        IF_ID_IR    <= Mem_C[EX_MEM_AluOut[9:0]];
        IF_ID_NPC   <= EX_MEM_AluOut + 32'd1;
        PC          <= EX_MEM_AluOut + 32'd1;
        IF_ID_valid <= 1'b1;
      end else if (hlt_seen) begin
        IF_ID_valid <= 1'b0;
      end else if (!stall) begin
        IF_ID_IR    <= Mem_C[PC[9:0]];
        IF_ID_NPC   <= PC + 32'd1;
        PC          <= PC + 32'd1;
        IF_ID_valid <= 1'b1;
      end
    end
  end

  // ID -> EX: register read; squashed on a taken branch, bubble on load-use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_IR    <= '0;
      ID_EX_NPC   <= '0;
      ID_EX_A     <= '0;
      ID_EX_B     <= '0;
      ID_EX_Imm   <= '0;
      ID_EX_valid <= 1'b0;
      ID_EX_wr    <= 1'b0;
      ID_EX_dst   <= '0;
    end else if (!halted) begin
      ID_EX_valid <= IF_ID_valid & ~taken & ~stall;
      ID_EX_IR    <= IF_ID_IR;
      ID_EX_NPC   <= IF_ID_NPC;
      ID_EX_A     <= id_a;
      ID_EX_B     <= id_b;
      ID_EX_Imm   <= id_imm;
      ID_EX_wr    <= id_wr;
      ID_EX_dst   <= id_dst;
    end
  end

  // EX -> MEM: latch result, store data and branch condition; squashed on a taken branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_MEM_op     <= '0;
      EX_MEM_AluOut <= '0;
      EX_MEM_B      <= '0;
      EX_MEM_Cond   <= 1'b0;
      EX_MEM_valid  <= 1'b0;
      EX_MEM_wr     <= 1'b0;
      EX_MEM_dst    <= '0;
    end else if (!halted) begin
      EX_MEM_valid  <= ID_EX_valid & ~taken;
      EX_MEM_Cond   <= ID_EX_valid & ~taken & ex_cond;
      EX_MEM_op     <= ex_op;
      EX_MEM_AluOut <= ex_alu;
      EX_MEM_B      <= mux_EX_out2;
      EX_MEM_wr     <= ID_EX_wr;
      EX_MEM_dst    <= ID_EX_dst;
    end
  end

  // MEM -> WB: data memory read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEM_WB_op     <= '0;
      MEM_WB_AluOut <= '0;
      MEM_WB_LMD    <= '0;
      MEM_WB_valid  <= 1'b0;
      MEM_WB_wr     <= 1'b0;
      MEM_WB_dst    <= '0;
    end else if (!halted) begin
      MEM_WB_valid  <= EX_MEM_valid;
      MEM_WB_op     <= EX_MEM_op;
      MEM_WB_AluOut <= EX_MEM_AluOut;
      MEM_WB_LMD    <= Mem_D[EX_MEM_AluOut[9:0]];
      MEM_WB_wr     <= EX_MEM_wr;
      MEM_WB_dst    <= EX_MEM_dst;
    end
  end

  // MEM: data memory store; no reset so preloaded contents survive
  always_ff @(posedge clk) begin
    if (EX_MEM_valid && (EX_MEM_op == OP_SW) && !halted)
      Mem_D[EX_MEM_AluOut[9:0]] <= EX_MEM_B;
  end

  // WB: HLT retiring freezes the machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted <= 1'b0;
    else if (MEM_WB_valid && (MEM_WB_op == OP_HLT)) halted <= 1'b1;
  end
endmodule

// File: tb/tb_mips32.sv
// tb_mips32: directed programs; expected register writebacks are queued by
// the stimulus and popped by a monitor watching the WB write port.

module tb_mips32;
  logic clk = 1'b0;
  logic rst_n;
  logic halted;

  mips32 dut (.clk(clk), .rst_n(rst_n), .halted(halted));

  always #5 clk = ~clk;

  typedef struct { logic [4:0] r; logic [31:0] v; } wb_t;
  wb_t exp_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010,
    OR_ = 6'b000011, SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000,
    SW = 6'b001001, ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100,
    BNEQZ = 6'b001101, BEQZ = 6'b001110, J = 6'b010000;
  localparam logic [31:0] HLT = 32'hFC00_0000;
  localparam logic [31:0] NOP = 32'hF800_0000;

  function automatic logic [31:0] r_op(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wb(input logic [4:0] r, input logic [31:0] v);
    wb_t e;
    e.r = r;
    e.v = v;
    exp_q.push_back(e);
  endtask

  // Monitor: every register-file write is compared against the head of the queue
  always @(negedge clk) begin : monitor
    wb_t e;
    if (rst_n === 1'b1 && dut.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got R%0d=%0h expected no write", dut.MEM_WB_dst, dut.wb_data);
      end else begin
        e = exp_q.pop_front();
        check("wb_reg", 32'(dut.MEM_WB_dst), 32'(e.r));
        check("wb_val", dut.wb_data, e.v);
      end
    end
  end

  task automatic start_test();
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      dut.Mem_C[i] = NOP;
      dut.Mem_D[i] = '0;
    end
    for (int i = 0; i < 32; i++) dut.R1.Reg[i] = '0;
  endtask

  task automatic run(input string name, input int exp_cycles);
    int n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    while (halted !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_halted"}, 32'(halted), 32'd1);
    check({name, "_cycles"}, n, exp_cycles);
    @(negedge clk);
    check({name, "_wb_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_pc",       dut.PC, 32'd0);
    check("rst_halted",   32'(halted), 32'd0);
    check("rst_ifid_ir",  dut.IF_ID_IR, 32'd0);
    check("rst_idex_a",   dut.ID_EX_A, 32'd0);
    check("rst_idex_b",   dut.ID_EX_B, 32'd0);
    check("rst_exmem_alu", dut.EX_MEM_AluOut, 32'd0);
    check("rst_exmem_cond", 32'(dut.EX_MEM_Cond), 32'd0);
    check("rst_memwb_alu", dut.MEM_WB_AluOut, 32'd0);

    // ADD then HLT; then asynchronous reset clears halted at once
    start_test();
    dut.R1.Reg[31] = 32'd31;
    dut.R1.Reg[0]  = 32'd1;
    dut.Mem_C[0] = r_op(ADD, 5'd21, 5'd31, 5'd0);
    dut.Mem_C[1] = HLT;
    expect_wb(5'd21, 32'd32);
    run("add", 6);
    check("add_r21", dut.R1.Reg[21], 32'd32);
    rst_n = 1'b0;
    #1;
    check("add_rst_halted", 32'(halted), 32'd0);
    check("add_rst_r21", dut.R1.Reg[21], 32'd32);

    // Back-to-back R-type writes to R21
    start_test();
    dut.R1.Reg[31] = 32'd31;
    dut.R1.Reg[0]  = 32'd1;
    dut.Mem_C[0] = r_op(SUB,  5'd21, 5'd31, 5'd0);
    dut.Mem_C[1] = r_op(AND_, 5'd21, 5'd31, 5'd0);
    dut.Mem_C[2] = r_op(OR_,  5'd21, 5'd31, 5'd0);
    dut.Mem_C[3] = r_op(SLT,  5'd21, 5'd31, 5'd0);
    dut.Mem_C[4] = HLT;
    expect_wb(5'd21, 32'd30);
    expect_wb(5'd21, 32'd1);
    expect_wb(5'd21, 32'd31);
    expect_wb(5'd21, 32'd0);
    run("rtype", 9);

    // Immediates and signed compares
    start_test();
    dut.R1.Reg[31] = 32'd31;
    dut.R1.Reg[30] = 32'hFFFF_FFFB;
    dut.R1.Reg[0]  = 32'd1;
    dut.Mem_C[0] = i_op(ADDI, 5'd21, 5'd31, 16'd3);
    dut.Mem_C[1] = i_op(SUBI, 5'd21, 5'd31, 16'd3);
    dut.Mem_C[2] = i_op(SLTI, 5'd21, 5'd31, 16'd3);
    dut.Mem_C[3] = i_op(SLTI, 5'd22, 5'd31, 16'hFFFF);
    dut.Mem_C[4] = i_op(SLTI, 5'd23, 5'd30, 16'd3);
    dut.Mem_C[5] = r_op(SLT,  5'd24, 5'd30, 5'd0);
    dut.Mem_C[6] = HLT;
    expect_wb(5'd21, 32'd34);
    expect_wb(5'd21, 32'd28);
    expect_wb(5'd21, 32'd0);
    expect_wb(5'd22, 32'd0);
    expect_wb(5'd23, 32'd1);
    expect_wb(5'd24, 32'd1);
    run("imm", 11);

    // Load then dependent use: one bubble
    start_test();
    dut.R1.Reg[31] = 32'd31;
    dut.R1.Reg[0]  = 32'd1;
    dut.R1.Reg[21] = 32'h55;
    dut.Mem_D[38]  = 32'd4;
    dut.Mem_C[0] = i_op(LW, 5'd21, 5'd31, 16'd7);
    dut.Mem_C[1] = r_op(ADD, 5'd20, 5'd21, 5'd0);
    dut.Mem_C[2] = HLT;
    expect_wb(5'd21, 32'd4);
    expect_wb(5'd20, 32'd5);
    run("loaduse", 8);

    // Forwarding (youngest writer wins), MUL, SW with forwarded data, overflow wrap
    start_test();
    dut.R1.Reg[31] = 32'd31;
    dut.R1.Reg[29] = 32'h7FFF_FFFF;
    dut.R1.Reg[0]  = 32'd1;
    dut.Mem_C[0] = i_op(ADDI, 5'd1, 5'd31, 16'd3);
    dut.Mem_C[1] = i_op(ADDI, 5'd1, 5'd1, 16'd1);
    dut.Mem_C[2] = r_op(ADD, 5'd2, 5'd1, 5'd1);
    dut.Mem_C[3] = r_op(MUL, 5'd3, 5'd2, 5'd1);
    dut.Mem_C[4] = i_op(SW, 5'd3, 5'd0, 16'd5);
    dut.Mem_C[5] = i_op(ADDI, 5'd4, 5'd29, 16'd1);
    dut.Mem_C[6] = HLT;
    expect_wb(5'd1, 32'd34);
    expect_wb(5'd1, 32'd35);
    expect_wb(5'd2, 32'd70);
    expect_wb(5'd3, 32'd2450);
    expect_wb(5'd4, 32'h8000_0000);
    run("fwd", 11);
    check("fwd_memd6", dut.Mem_D[6], 32'd2450);

    // Branches and jump, including an HLT in a squashed slot
    start_test();
    dut.R1.Reg[31] = 32'd31;
    dut.R1.Reg[0]  = 32'd1;
    dut.Mem_C[0]  = i_op(BEQZ, 5'd0, 5'd0, 16'hFFFF);
    dut.Mem_C[1]  = i_op(ADDI, 5'd5, 5'd31, 16'd0);
    dut.Mem_C[2]  = i_op(ADDI, 5'd0, 5'd0, 16'hFFFF);
    dut.Mem_C[3]  = i_op(BEQZ, 5'd0, 5'd0, 16'd2);
    dut.Mem_C[4]  = i_op(ADDI, 5'd6, 5'd31, 16'd1);
    dut.Mem_C[5]  = i_op(ADDI, 5'd7, 5'd31, 16'd1);
    dut.Mem_C[6]  = {J, 26'd9};
    dut.Mem_C[7]  = i_op(ADDI, 5'd8, 5'd31, 16'd1);
    dut.Mem_C[8]  = i_op(ADDI, 5'd9, 5'd31, 16'd1);
    dut.Mem_C[9]  = i_op(BNEQZ, 5'd0, 5'd31, 16'd2);
    dut.Mem_C[10] = HLT;
    dut.Mem_C[11] = i_op(ADDI, 5'd11, 5'd31, 16'd1);
    dut.Mem_C[12] = i_op(ADDI, 5'd12, 5'd31, 16'd2);
    dut.Mem_C[13] = HLT;
    expect_wb(5'd5, 32'd31);
    expect_wb(5'd0, 32'd0);
    expect_wb(5'd12, 32'd33);
    run("branch", 18);
    check("branch_r6",  dut.R1.Reg[6],  32'd0);
    check("branch_r7",  dut.R1.Reg[7],  32'd0);
    check("branch_r8",  dut.R1.Reg[8],  32'd0);
    check("branch_r9",  dut.R1.Reg[9],  32'd0);
    check("branch_r11", dut.R1.Reg[11], 32'd0);

    // Reset in the middle of a jump loop
    start_test();
    dut.R1.Reg[31] = 32'd31;
    dut.Mem_C[0] = i_op(ADDI, 5'd14, 5'd31, 16'd5);
    dut.Mem_C[1] = i_op(SW, 5'd14, 5'd31, 16'd10);
    dut.Mem_C[2] = {J, 26'd2};
    expect_wb(5'd14, 32'd36);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("midrst_pc_before", 32'(dut.PC > 32'd2), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_pc", dut.PC, 32'd0);
    check("midrst_halted", 32'(halted), 32'd0);
    check("midrst_cond", 32'(dut.EX_MEM_Cond), 32'd0);
    check("midrst_r14", dut.R1.Reg[14], 32'd36);
    check("midrst_memd41", dut.Mem_D[41], 32'd36);
    check("midrst_wb_pending", exp_q.size(), 0);
    expect_wb(5'd14, 32'd36);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_ir", dut.IF_ID_IR, i_op(ADDI, 5'd14, 5'd31, 16'd5));
    check("restart_pc", dut.PC, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check("restart_wb_pending", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
